// File: rtl/hazard_stall_ctrl.sv
// Purpose: load-use / branch / memory-busy sequencing for the IF/ID and ID/EX pipeline registers.
// Latency: all pipe controls are combinational, same-cycle; MemTimeout and StallCnt are registered.
// Backpressure: MemBusy freezes the pipe and the stall sequencer; the watchdog flags long freezes.
module hazard_stall_ctrl #(
    parameter int LU_STALL = 1,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ID_EX_MR,
    input  logic [3:0]       ID_EX_WN,
    input  logic [3:0]       IF_ID_RN1,
    input  logic [3:0]       IF_ID_RN2,
    input  logic             IF_ID_Use1,
    input  logic             IF_ID_Use2,
    input  logic             BrTaken,
    input  logic             MemBusy,
    output logic             PCWr,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ST,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Hold,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int             WW     = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]  W_MAX  = WW'(MAX_WAIT);
    localparam logic [WW-1:0]  W_LAST = WW'(MAX_WAIT - 1);
    localparam logic [1:0]     L_INIT = 2'(LU_STALL - 1);

    typedef enum logic {
        S_RUN = 1'b0,
        S_LU  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_lcnt;
    logic [1:0]       w_lcnt_nxt;
    logic [WW-1:0]    r_wcnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_hz;
    logic             w_stall;
    logic             w_pcwr;
    logic             w_ifid_wr;
    logic             w_flush;
    logic             w_st;
    logic             w_idex_hold;
    logic             w_exmem_hold;

    // Load-use hazard: EX holds a load whose destination a live ID source reads (R0 included).
    always_comb begin
        w_hz = ID_EX_MR &
               ((IF_ID_Use1 & (IF_ID_RN1 == ID_EX_WN)) |
                (IF_ID_Use2 & (IF_ID_RN2 == ID_EX_WN)));
        w_stall = w_hz | (r_state == S_LU);
    end

    // Priority decode: memory freeze, then branch squash, then load-use bubble, then normal flow.
    always_comb begin
        w_pcwr       = 1'b1;
        w_ifid_wr    = 1'b1;
        w_flush      = 1'b0;
        w_st         = 1'b0;
        w_idex_hold  = 1'b0;
        w_exmem_hold = 1'b0;
        w_state_nxt  = r_state;
        w_lcnt_nxt   = r_lcnt;
        if (MemBusy) begin
            // EX is frozen, so a pending branch or hazard simply re-presents later.
            w_pcwr       = 1'b0;
            w_ifid_wr    = 1'b0;
            w_idex_hold  = 1'b1;
            w_exmem_hold = 1'b1;
        end else if (BrTaken) begin
            // Squash the wrong-path instructions; any bubble sequence in flight is moot.
            w_flush     = 1'b1;
            w_st        = 1'b1;
            w_state_nxt = S_RUN;
            w_lcnt_nxt  = 2'd0;
        end else if (w_stall) begin
            w_pcwr    = 1'b0;
            w_ifid_wr = 1'b0;
            w_st      = 1'b1;
            if (r_state == S_RUN) begin
                // This cycle is the first bubble; extra bubbles are counted down in S_LU.
                if (LU_STALL > 1) begin
                    w_state_nxt = S_LU;
                    w_lcnt_nxt  = L_INIT;
                end
            end else begin
                w_lcnt_nxt = r_lcnt - 2'd1;
                if (r_lcnt == 2'd1) begin
                    w_state_nxt = S_RUN;
                end
            end
        end
    end

    // Reset forces a flushed, frozen front end regardless of the decode above.
    assign PCWr        = Rst ? 1'b0 : w_pcwr;
    assign IF_ID_Wr    = Rst ? 1'b0 : w_ifid_wr;
    assign IF_ID_Flush = Rst ? 1'b1 : w_flush;
    assign ST          = Rst ? 1'b1 : w_st;
    assign ID_EX_Hold  = Rst ? 1'b0 : w_idex_hold;
    assign EX_MEM_Hold = Rst ? 1'b0 : w_exmem_hold;
    assign MemTimeout  = r_timeout;
    assign StallCnt    = r_stall_cnt;

    // Sequencer state and bubble down-counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_RUN;
            r_lcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    // Busy watchdog: counts consecutive busy cycles, sets a sticky error at MAX_WAIT.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else if (MemBusy) begin
            if (r_wcnt != W_MAX) begin
                r_wcnt <= r_wcnt + WW'(1);
            end
            if (r_wcnt == W_LAST) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wcnt <= '0;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pcwr && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (LU_STALL 1/2/3, varied watchdog and counter widths).
// Outputs compared every cycle at the falling edge against a bubble-budget model; inputs change 1ns after rising edge.
// Directed sequences pin the model with literal values, then randomized traffic runs against the model.
module tb_hazard_stall_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       mr = 1'b0, u1 = 1'b0, u2 = 1'b0, br = 1'b0, busy = 1'b0;
    logic [3:0] wn = 4'd0, rn1 = 4'd0, rn2 = 4'd0;

    logic [2:0] pcwr, ifwr, fl, st, idh, exh, to;
    logic [15:0] sc0;
    logic [3:0]  sc1;
    logic [2:0]  sc2;

    int total = 0;
    int bad   = 0;

    // model parameters per instance
    int lu   [3] = '{1, 2, 3};
    int mw   [3] = '{64, 5, 2};
    int cmax [3] = '{65535, 15, 7};
    // model state: bubbles still owed, busy run length, sticky timeout, stall count
    int pend [3] = '{0, 0, 0};
    int run  [3] = '{0, 0, 0};
    int mto  [3] = '{0, 0, 0};
    int cnt  [3] = '{0, 0, 0};

    always #5 Clk = ~Clk;

    hazard_stall_ctrl #(.LU_STALL(1), .MAX_WAIT(64), .CNT_W(16)) u0 (
        .Clk(Clk), .Rst(Rst), .ID_EX_MR(mr), .ID_EX_WN(wn), .IF_ID_RN1(rn1), .IF_ID_RN2(rn2),
        .IF_ID_Use1(u1), .IF_ID_Use2(u2), .BrTaken(br), .MemBusy(busy),
        .PCWr(pcwr[0]), .IF_ID_Wr(ifwr[0]), .IF_ID_Flush(fl[0]), .ST(st[0]),
        .ID_EX_Hold(idh[0]), .EX_MEM_Hold(exh[0]), .MemTimeout(to[0]), .StallCnt(sc0));
    hazard_stall_ctrl #(.LU_STALL(2), .MAX_WAIT(5), .CNT_W(4)) u1_i (
        .Clk(Clk), .Rst(Rst), .ID_EX_MR(mr), .ID_EX_WN(wn), .IF_ID_RN1(rn1), .IF_ID_RN2(rn2),
        .IF_ID_Use1(u1), .IF_ID_Use2(u2), .BrTaken(br), .MemBusy(busy),
        .PCWr(pcwr[1]), .IF_ID_Wr(ifwr[1]), .IF_ID_Flush(fl[1]), .ST(st[1]),
        .ID_EX_Hold(idh[1]), .EX_MEM_Hold(exh[1]), .MemTimeout(to[1]), .StallCnt(sc1));
    hazard_stall_ctrl #(.LU_STALL(3), .MAX_WAIT(2), .CNT_W(3)) u2_i (
        .Clk(Clk), .Rst(Rst), .ID_EX_MR(mr), .ID_EX_WN(wn), .IF_ID_RN1(rn1), .IF_ID_RN2(rn2),
        .IF_ID_Use1(u1), .IF_ID_Use2(u2), .BrTaken(br), .MemBusy(busy),
        .PCWr(pcwr[2]), .IF_ID_Wr(ifwr[2]), .IF_ID_Flush(fl[2]), .ST(st[2]),
        .ID_EX_Hold(idh[2]), .EX_MEM_Hold(exh[2]), .MemTimeout(to[2]), .StallCnt(sc2));

    task automatic check(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", nm, idx, $time, act, exp);
        end
    endtask

    function automatic int sc_of(input int i);
        if (i == 0) return int'(sc0);
        if (i == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    // Per-cycle model comparison at the falling edge, then advance the model to the next cycle.
    always @(negedge Clk) begin
        bit hz;
        int e_pc, e_ifw, e_fl, e_st, e_idh, e_exh, npend;
        hz = mr && ((u1 && (rn1 == wn)) || (u2 && (rn2 == wn)));
        for (int i = 0; i < 3; i++) begin
            npend = pend[i];
            if (Rst) begin
                pend[i] = 0; run[i] = 0; mto[i] = 0; cnt[i] = 0; npend = 0;
                e_pc = 0; e_ifw = 0; e_fl = 1; e_st = 1; e_idh = 0; e_exh = 0;
            end else if (busy) begin
                e_pc = 0; e_ifw = 0; e_fl = 0; e_st = 0; e_idh = 1; e_exh = 1;
            end else if (br) begin
                e_pc = 1; e_ifw = 1; e_fl = 1; e_st = 1; e_idh = 0; e_exh = 0;
                npend = 0;
            end else if (hz || pend[i] > 0) begin
                e_pc = 0; e_ifw = 0; e_fl = 0; e_st = 1; e_idh = 0; e_exh = 0;
                npend = (pend[i] > 0) ? pend[i] - 1 : lu[i] - 1;
            end else begin
                e_pc = 1; e_ifw = 1; e_fl = 0; e_st = 0; e_idh = 0; e_exh = 0;
            end
            check("PCWr",        i, int'(pcwr[i]), e_pc);
            check("IF_ID_Wr",    i, int'(ifwr[i]), e_ifw);
            check("IF_ID_Flush", i, int'(fl[i]),   e_fl);
            check("ST",          i, int'(st[i]),   e_st);
            check("ID_EX_Hold",  i, int'(idh[i]),  e_idh);
            check("EX_MEM_Hold", i, int'(exh[i]),  e_exh);
            check("MemTimeout",  i, int'(to[i]),   mto[i]);
            check("StallCnt",    i, sc_of(i),      cnt[i]);
            if (!Rst) begin
                if (e_pc == 0 && cnt[i] < cmax[i]) cnt[i]++;
                if (busy) begin
                    if (run[i] == mw[i] - 1) mto[i] = 1;
                    if (run[i] < mw[i]) run[i]++;
                end else begin
                    run[i] = 0;
                end
                pend[i] = npend;
            end
        end
    end

    task automatic set_in(input bit m, input int w, input int r1, input int r2,
                          input bit a1, input bit a2, input bit b, input bit bz);
        mr = m; wn = 4'(w); rn1 = 4'(r1); rn2 = 4'(r2);
        u1 = a1; u2 = a2; br = b; busy = bz;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    initial begin
        idle();
        step();
        step();

        // 1/3: one hazard -> 1, 2, 3 bubbles for LU_STALL 1, 2, 3
        do_reset();
        set_in(1, 5, 5, 0, 1, 0, 0, 0);
        #2;
        check("lit_hz_pcwr", 0, int'(pcwr), 0);
        check("lit_hz_st",   0, int'(st),   7);
        step();
        idle();
        repeat (3) step();
        check("lit_cnt_lu1", 0, int'(sc0), 1);
        check("lit_cnt_lu2", 1, int'(sc1), 2);
        check("lit_cnt_lu3", 2, int'(sc2), 3);

        // 2: use bit clear, or different register -> no stall
        do_reset();
        set_in(1, 5, 5, 0, 0, 0, 0, 0);
        #2;
        check("lit_nouse_pcwr", 0, int'(pcwr), 7);
        check("lit_nouse_st",   0, int'(st),   0);
        step();
        set_in(1, 6, 5, 5, 1, 1, 0, 0);
        #2;
        check("lit_diff_pcwr", 0, int'(pcwr), 7);
        step();
        check("lit_nostall_cnt", 0, int'(sc0), 0);

        // 4: branch on the 2nd stall cycle cancels the remaining bubble (LU_STALL=3)
        do_reset();
        set_in(1, 5, 5, 0, 1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        check("lit_br_pcwr",  2, int'(pcwr[2]), 1);
        check("lit_br_flush", 2, int'(fl[2]),   1);
        check("lit_br_st",    2, int'(st[2]),   1);
        step();
        idle();
        #2;
        check("lit_after_br_pcwr", 2, int'(pcwr[2]), 1);
        check("lit_after_br_st",   2, int'(st[2]),   0);
        step();
        check("lit_br_cnt", 2, int'(sc2), 1);

        // 5a: busy during the stall freezes it; stall resumes afterwards
        do_reset();
        set_in(1, 5, 5, 0, 1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) begin
            #2;
            check("lit_busy_hold", 2, int'({idh[2], exh[2]}), 3);
            step();
        end
        idle();
        #2;
        check("lit_resume_st_a", 2, int'(st[2]), 1);
        step();
        #2;
        check("lit_resume_st_b", 2, int'(st[2]), 1);
        step();
        #2;
        check("lit_resume_run", 2, int'(pcwr[2]), 1);
        step();
        check("lit_resume_cnt", 2, int'(sc2), 6);
        check("lit_to_mw2",     2, int'(to[2]), 1);
        check("lit_to_mw5",     1, int'(to[1]), 0);

        // 5b: 64 busy cycles -> MemTimeout from cycle 65, sticky; counters saturate
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (63) step();
        check("lit_to_63", 0, int'(to[0]), 0);
        step();
        check("lit_to_64", 0, int'(to[0]), 1);
        idle();
        step();
        check("lit_to_sticky", 0, int'(to[0]), 1);
        check("lit_sat_cnt0",  0, int'(sc0), 64);
        check("lit_sat_cnt1",  1, int'(sc1), 15);
        check("lit_sat_cnt2",  2, int'(sc2), 7);

        // 6: async reset in the middle of a stall
        do_reset();
        set_in(1, 5, 5, 0, 1, 0, 0, 0);
        step();
        idle();
        #2;
        Rst = 1'b1;
        #1;
        check("lit_rst_pcwr",  0, int'(pcwr), 0);
        check("lit_rst_flush", 0, int'(fl),   7);
        check("lit_rst_st",    0, int'(st),   7);
        check("lit_rst_cnt",   2, int'(sc2),  0);
        step();
        Rst = 1'b0;
        #2;
        check("lit_post_rst_pcwr", 0, int'(pcwr), 7);
        check("lit_post_rst_st",   0, int'(st),   0);
        check("lit_post_rst_to",   0, int'(to),   0);
        step();

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            Rst = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) begin
                busy = 1'b1;
                repeat ($urandom_range(2, 8)) step();
            end
            step();
        end
        Rst = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
